// File: rtl/sorter_rr_sched_if.sv
// Request/sorter/response bundle for the shared-sorter scheduler.
// Ports: requester valid/ready/data, sorter issue/return, per-requester response.
interface sorter_rr_sched_if #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4
);
    logic [NREQ-1:0]             req_valid_i;
    logic [NREQ-1:0]             req_ready_o;
    logic [NREQ*8*DATAWIDTH-1:0] req_data_i;
    logic                        sort_valid_o;
    logic [8*DATAWIDTH-1:0]      sort_data_o;
    logic                        sort_valid_i;
    logic [8*DATAWIDTH-1:0]      sort_data_i;
    logic [NREQ-1:0]             rsp_valid_o;
    logic [8*DATAWIDTH-1:0]      rsp_data_o;

    // Scheduler side.
    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  sort_valid_i,
        input  sort_data_i,
        output req_ready_o,
        output sort_valid_o,
        output sort_data_o,
        output rsp_valid_o,
        output rsp_data_o
    );

    // Environment side: requesters plus the sorter datapath.
    modport master (
        output req_valid_i,
        output req_data_i,
        output sort_valid_i,
        output sort_data_i,
        input  req_ready_o,
        input  sort_valid_o,
        input  sort_data_o,
        input  rsp_valid_o,
        input  rsp_data_o
    );
endinterface

// File: rtl/sorter_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency 8-input sorter among NREQ requesters.
// Ports: clk_i, rst_i (sync, active-high), flush_i, bus (slave), idle_o, err_o (sticky).
module sorter_rr_sched #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int LAT       = 6,
    parameter int MAX_OUT   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    sorter_rr_sched_if.slave bus,
    output logic             idle_o,
    output logic             err_o
);
    localparam int VW  = 8 * DATAWIDTH;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
    localparam logic [IDW:0]  NREQ_W  = (IDW+1)'(NREQ);

    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_cnt [NREQ];
    logic [LAT-1:0] r_tag_v;
    logic [IDW-1:0] r_tag_id [LAT];
    logic           r_err;

    logic [NREQ-1:0]   w_elig;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [NREQ-1:0]   w_gnt;
    logic [NREQ-1:0]   w_rsp;
    logic [IDW-1:0]    w_off;
    logic [IDW-1:0]    w_gid;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [IDW:0]      w_sum;
    logic [IDW:0]      w_inc;
    logic              w_gv;
    logic              w_tag_v;
    logic [IDW-1:0]    w_tag_id;
    logic              w_hit;
    logic              w_cnt_zero;
    logic [VW-1:0]     w_sdata;

    // Reset also masks eligibility so nothing is granted while rst_i is high.
    always_comb begin
        w_elig = '0;
        for (int r = 0; r < NREQ; r++) begin
            w_elig[r] = bus.req_valid_i[r]
                      && (r_cnt[r] < CNT_MAX)
                      && !flush_i
                      && !rst_i;
        end
    end

    // Rotate so bit k is requester (ptr+k) mod NREQ; the lowest set bit wins.
    assign w_dbl = {w_elig, w_elig} >> r_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_gv  = 1'b0;
        w_off = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gv && w_rot[k]) begin
                w_gv  = 1'b1;
                w_off = IDW'(k);
            end
        end
    end

    // Map the rotated offset back to a requester id, and precompute the
    // pointer that follows it; both wrap modulo NREQ.
    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= NREQ_W) begin
            w_sum = w_sum - NREQ_W;
        end
        w_gid = w_sum[IDW-1:0];
        w_inc = {1'b0, w_gid} + (IDW+1)'(1);
        if (w_inc >= NREQ_W) begin
            w_inc = '0;
        end
        w_ptr_nxt = w_inc[IDW-1:0];
    end

    assign w_gnt = w_gv ? (NREQ'(1) << w_gid) : '0;

    always_comb begin
        w_sdata = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (w_gnt[r]) begin
                w_sdata = bus.req_data_i[r*VW +: VW];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_gv) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Tag pipeline mirrors the sorter: one stage per cycle of latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tag_v <= '0;
        end else begin
            r_tag_v[0] <= w_gv;
            for (int s = 1; s < LAT; s++) begin
                r_tag_v[s] <= r_tag_v[s-1];
            end
        end
    end

    // Ids are only meaningful alongside a set valid bit, so no reset.
    always_ff @(posedge clk_i) begin
        r_tag_id[0] <= w_gid;
        for (int s = 1; s < LAT; s++) begin
            r_tag_id[s] <= r_tag_id[s-1];
        end
    end

    assign w_tag_v  = r_tag_v[LAT-1];
    assign w_tag_id = r_tag_id[LAT-1];

    // A result is routed only when both the sorter and the tag agree.
    assign w_hit = w_tag_v & bus.sort_valid_i & ~rst_i;
    assign w_rsp = w_hit ? (NREQ'(1) << w_tag_id) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (bus.sort_valid_i != w_tag_v) begin
            r_err <= 1'b1;
        end
    end

    // Grant and response together leave the count unchanged; a response
    // at zero (only after misalignment) saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREQ; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                case ({w_gnt[r], w_rsp[r]})
                    2'b10: r_cnt[r] <= r_cnt[r] + CW'(1);
                    2'b01: begin
                        if (r_cnt[r] != '0) begin
                            r_cnt[r] <= r_cnt[r] - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_cnt_zero = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            if (r_cnt[r] != '0) begin
                w_cnt_zero = 1'b0;
            end
        end
    end

    assign idle_o = rst_i | (w_cnt_zero & ~|r_tag_v);
    assign err_o  = r_err;

    assign bus.req_ready_o  = w_gnt;
    assign bus.sort_valid_o = w_gv;
    assign bus.sort_data_o  = w_sdata;
    assign bus.rsp_valid_o  = w_rsp;
    assign bus.rsp_data_o   = bus.sort_data_i;
endmodule

// File: tb/tb_sorter_rr_sched.sv
// Bench for sorter_rr_sched: behavioural sorter, round-robin reference model,
// and a timed scoreboard of expected responses.
module tb_sorter_rr_sched;
    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int LAT  = 6;
    localparam int MAXO = 2;
    localparam int VW   = 8 * DW;

    typedef struct {
        int             id;
        logic [VW-1:0]  d;
        int             due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic stray = 1'b0;
    logic idle;
    logic err;

    sorter_rr_sched_if #(.DATAWIDTH(DW), .NREQ(N)) ifc ();

    sorter_rr_sched #(
        .DATAWIDTH(DW),
        .NREQ(N),
        .LAT(LAT),
        .MAX_OUT(MAXO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .bus(ifc.slave),
        .idle_o(idle),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    function automatic logic [VW-1:0] sort8(input logic [VW-1:0] v);
        logic [DW-1:0] e [8];
        logic [DW-1:0] t;
        logic [VW-1:0] o;
        for (int i = 0; i < 8; i++) e[i] = v[i*DW +: DW];
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (e[j] > e[j+1]) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
        for (int i = 0; i < 8; i++) o[i*DW +: DW] = e[i];
        return o;
    endfunction

    // Sorter model: fixed LAT-cycle delay, shares the reset.
    logic [LAT-1:0] pv;
    logic [VW-1:0]  pd [LAT];
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else     pv <= {pv[LAT-2:0], ifc.sort_valid_o};
        pd[0] <= sort8(ifc.sort_data_o);
        for (int s = 1; s < LAT; s++) pd[s] <= pd[s-1];
    end
    assign ifc.sort_valid_i = pv[LAT-1] | stray;
    assign ifc.sort_data_i  = pd[LAT-1];

    // Reference model state.
    int             m_ptr = 0;
    int             m_cnt [N];
    logic           m_gv = 1'b0;
    int             m_g = 0;
    logic           mon_v = 1'b0;
    int             mon_id = 0;
    exp_t           mon_e;
    exp_t           sbq [$];
    logic [N-1:0]   exp_rdy;
    logic [VW-1:0]  exp_sd;
    logic [N-1:0]   exp_rv;

    function automatic int pred(input logic [N-1:0] v, input logic fl, input logic r);
        if (r || fl) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v[i] && m_cnt[i] < MAXO) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_ptr <= 0;
            for (int i = 0; i < N; i++) m_cnt[i] <= 0;
        end else begin
            if (m_gv) m_ptr <= (m_g + 1) % N;
            for (int i = 0; i < N; i++)
                m_cnt[i] <= m_cnt[i] + ((m_gv && m_g == i) ? 1 : 0)
                                     - ((mon_v && mon_id == i) ? 1 : 0);
        end
    end

    // Response monitor: pops the entry due this cycle, if any.
    always @(negedge clk) begin
        #2;
        mon_v  = 1'b0;
        mon_id = 0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            mon_e  = sbq.pop_front();
            mon_v  = 1'b1;
            mon_id = mon_e.id;
        end
        exp_rv = mon_v ? (N'(1) << mon_id) : '0;
        total++;
        if (ifc.rsp_valid_o !== exp_rv) begin
            bad++;
            $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, ifc.rsp_valid_o, exp_rv);
        end
        if (mon_v) begin
            total++;
            if (ifc.rsp_data_o !== mon_e.d) begin
                bad++;
                $display("FAIL rsp_data cyc=%0d got=%h want=%h", cyc, ifc.rsp_data_o, mon_e.d);
            end
        end
    end

    // Drive one cycle of stimulus and predict its grant; returns #1 after negedge.
    task automatic step(input logic [N-1:0] v, input logic fl, input logic r, input logic st);
        int g;
        @(negedge clk);
        rst   = r;
        flush = fl;
        stray = st;
        ifc.req_valid_i = v;
        for (int i = 0; i < N; i++) ifc.req_data_i[i*VW +: VW] = {$urandom, $urandom};
        if (r) sbq.delete();
        g = pred(v, fl, r);
        m_gv = (g >= 0);
        m_g  = (g < 0) ? 0 : g;
        exp_rdy = m_gv ? (N'(1) << m_g) : '0;
        exp_sd  = m_gv ? ifc.req_data_i[m_g*VW +: VW] : '0;
        if (m_gv) sbq.push_back('{m_g, sort8(exp_sd), cyc + LAT});
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        do begin
            step('0, 1'b0, 1'b0, 1'b0);
            k++;
        end while (idle !== 1'b1 && k < 40);
        total++;
        if (idle !== 1'b1) begin
            bad++;
            $display("FAIL drain idle=%b want=1", idle);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(4'hF, 1'b0, 1'b1, 1'b0);
            total += 3;
            if (ifc.req_ready_o !== 4'b0000) begin
                bad++; $display("FAIL rst_ready got=%b want=0000", ifc.req_ready_o);
            end
            if (ifc.sort_valid_o !== 1'b0) begin
                bad++; $display("FAIL rst_sort_valid got=%b want=0", ifc.sort_valid_o);
            end
            if (idle !== 1'b1) begin
                bad++; $display("FAIL rst_idle got=%b want=1", idle);
            end
        end
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL rst_err got=%b want=0", err);
        end
    endtask

    task automatic test_all();
        logic [N-1:0] pat;
        for (int k = 0; k < 8; k++) begin
            step(4'hF, 1'b0, 1'b0, 1'b0);
            pat = 4'b0001 << (k % 4);
            total += 4;
            if (ifc.req_ready_o !== pat) begin
                bad++; $display("FAIL all_order k=%0d got=%b want=%b", k, ifc.req_ready_o, pat);
            end
            if (ifc.req_ready_o !== exp_rdy) begin
                bad++; $display("FAIL all_model k=%0d got=%b want=%b", k, ifc.req_ready_o, exp_rdy);
            end
            if (ifc.sort_valid_o !== 1'b1) begin
                bad++; $display("FAIL all_sv k=%0d got=%b want=1", k, ifc.sort_valid_o);
            end
            if (ifc.sort_data_o !== exp_sd) begin
                bad++; $display("FAIL all_sd k=%0d got=%h want=%h", k, ifc.sort_data_o, exp_sd);
            end
        end
        drain();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL all_err got=%b want=0", err);
        end
    endtask

    task automatic test_single();
        logic [VW-1:0] vec;
        logic [VW-1:0] want;
        vec = 64'h0703050108020604;
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        ifc.req_data_i[1*VW +: VW] = vec;
        want = sort8(vec);
        if (sbq.size() > 0) sbq[sbq.size()-1].d = want;
        #1;
        total += 3;
        if (ifc.req_ready_o !== 4'b0010) begin
            bad++; $display("FAIL single_ready got=%b want=0010", ifc.req_ready_o);
        end
        if (ifc.sort_valid_o !== 1'b1) begin
            bad++; $display("FAIL single_sv got=%b want=1", ifc.sort_valid_o);
        end
        if (ifc.sort_data_o !== vec) begin
            bad++; $display("FAIL single_sd got=%h want=%h", ifc.sort_data_o, vec);
        end
        for (int k = 1; k <= 7; k++) begin
            step('0, 1'b0, 1'b0, 1'b0);
            total++;
            if (idle !== (k >= 7)) begin
                bad++; $display("FAIL single_idle k=%0d got=%b want=%b", k, idle, (k >= 7));
            end
        end
    endtask

    task automatic test_maxout();
        logic [N-1:0] pat;
        for (int k = 0; k < 9; k++) begin
            step(4'b0001, 1'b0, 1'b0, 1'b0);
            pat = (k <= 1 || k >= 7) ? 4'b0001 : 4'b0000;
            total++;
            if (ifc.req_ready_o !== exp_rdy) begin
                bad++; $display("FAIL max_model k=%0d got=%b want=%b", k, ifc.req_ready_o, exp_rdy);
            end
            if (k < 8) begin
                total++;
                if (ifc.req_ready_o !== pat) begin
                    bad++; $display("FAIL max_cap k=%0d got=%b want=%b", k, ifc.req_ready_o, pat);
                end
            end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            step(4'b0111, 1'b0, 1'b0, 1'b0);
            total++;
            if (ifc.sort_valid_o !== 1'b1 || ifc.req_ready_o !== exp_rdy) begin
                bad++; $display("FAIL flush_fill k=%0d got=%b want=%b", k, ifc.req_ready_o, exp_rdy);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            step(4'hF, 1'b1, 1'b0, 1'b0);
            total += 2;
            if (ifc.req_ready_o !== 4'b0000) begin
                bad++; $display("FAIL flush_block k=%0d got=%b want=0000", k, ifc.req_ready_o);
            end
            if (idle !== (k >= 7)) begin
                bad++; $display("FAIL flush_idle k=%0d got=%b want=%b", k, idle, (k >= 7));
            end
        end
        drain();
    endtask

    task automatic test_stray();
        step('0, 1'b0, 1'b0, 1'b1);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL stray_pre got=%b want=0", err);
        end
        for (int k = 0; k < 4; k++) begin
            step('0, 1'b0, 1'b0, 1'b0);
            total++;
            if (err !== 1'b1) begin
                bad++; $display("FAIL stray_err k=%0d got=%b want=1", k, err);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) step(4'hF, 1'b0, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b1, 1'b0);
        total += 2;
        if (ifc.req_ready_o !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_ready got=%b want=0000", ifc.req_ready_o);
        end
        if (idle !== 1'b1) begin
            bad++; $display("FAIL mid_rst_idle got=%b want=1", idle);
        end
        step(4'b0110, 1'b0, 1'b0, 1'b0);
        total += 3;
        if (idle !== 1'b1) begin
            bad++; $display("FAIL mid_idle got=%b want=1", idle);
        end
        if (err !== 1'b0) begin
            bad++; $display("FAIL mid_err got=%b want=0", err);
        end
        if (ifc.req_ready_o !== 4'b0010) begin
            bad++; $display("FAIL mid_first got=%b want=0010", ifc.req_ready_o);
        end
        drain();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL mid_err_end got=%b want=0", err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_all();
        test_single();
        test_maxout();
        test_flush();
        test_stray();
        test_reset_mid();
        step('0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sorter_rr_sched.md
# sorter_rr_sched

Round-robin scheduler that shares one pipelined 8-input bitonic sorter between `NREQ` requesters. It grants at most one 8-element vector per cycle into the sorter and tracks the requester ID of each in-flight vector in a `LAT`-deep tag pipeline. It routes each sorted result back to the requester that issued it, and caps each requester's outstanding vectors at `MAX_OUT`. It sits between the top-k front-end request sources and the shared sorter datapath.

## Interface
Parameters:
- `DATAWIDTH`, 8, element width
- `NREQ`, 4, number of requesters (≥2)
- `LAT`, 6, fixed sorter latency in cycles from `sort_valid_o` to `sort_valid_i` (≥1)
- `MAX_OUT`, 4, maximum in-flight vectors per requester (≥1)

Ports:
- `clk_i`  in  1  clock; all logic rising-edge
- `rst_i`  in  1  synchronous, active-high reset
- `req_valid_i`  in  NREQ  requester r has a vector
- `req_ready_o`  out  NREQ  grant; a transfer occurs when valid & ready
- `req_data_i`  in  NREQ*8*DATAWIDTH  requester r vector at slice r
- `sort_valid_o`  out  1  vector issued to sorter this cycle
- `sort_data_o`  out  8*DATAWIDTH  granted vector
- `sort_valid_i`  in  1  sorter result valid
- `sort_data_i`  in  8*DATAWIDTH  sorter result
- `rsp_valid_o`  out  NREQ  one-hot; result for requester r (always accepted)
- `rsp_data_o`  out  8*DATAWIDTH  result data
- `flush_i`  in  1  level; while high, no new grants
- `idle_o`  out  1  no vectors in flight
- `err_o`  out  1  sticky; result/tag misalignment

## Operation
- Eligibility: r is eligible iff `req_valid_i[r]`, `cnt[r] < MAX_OUT`, and `!flush_i`.
- Arbitration:
  - Combinational, round-robin from pointer `ptr`. Grant the first eligible r scanning `ptr, ptr+1, … mod NREQ`.
  - `req_ready_o` is one-hot or zero.
  - On a grant to g, `ptr <= (g+1) mod NREQ`. With no grant, `ptr` holds.
  - `req_ready_o` may depend on `req_valid_i` in the same cycle.
- Issue: `sort_valid_o` = OR of grants. `sort_data_o` = granted slice, combinational pass-through. When there is no grant, `sort_data_o` is don't-care.
- Tag pipeline: `LAT` stages of {valid, id[$clog2(NREQ)-1:0]}. Stage 0 loads {`sort_valid_o`, g} every cycle and the pipeline shifts unconditionally. Stage `LAT-1` output = `tag_v`, `tag_id`.
- Response, combinational from pipeline output:
  - `rsp_valid_o[tag_id] = tag_v & sort_valid_i`.
  - `rsp_data_o = sort_data_i`.
- Misalignment: if `sort_valid_i != tag_v` in any cycle, `err_o <= 1`. It stays 1 until reset. Routing continues using `tag_v & sort_valid_i`.
- Outstanding counters `cnt[r]`, width `$clog2(MAX_OUT+1)`:
  - +1 on grant to r.
  - −1 on `rsp_valid_o[r]`.
  - Grant and response to the same r in the same cycle: unchanged.
  - Never exceeds `MAX_OUT`.
  - Decrement when the counter is at 0 (possible only after misalignment): saturate at 0.
- `idle_o` = all `cnt` zero and no tag valid in any stage, combinational.
- Flush: `flush_i` blocks new grants only. In-flight vectors complete normally. `idle_o` rises once the pipeline drains.

## Timing
- Reset values:
  - `ptr`=0, all `cnt`=0, all tag valids=0, `err_o`=0.
  - Consequently `req_ready_o`=0, `sort_valid_o`=0, `rsp_valid_o`=0, `idle_o`=1 while `rst_i` is high.
- Grant-to-response latency is exactly `LAT` cycles. Vector granted at cycle t produces `rsp_valid_o` at cycle t+`LAT` (`sort_valid_i` expected at t+`LAT`).
- Throughput: one vector per cycle, limited by `NREQ*MAX_OUT` total in flight.
- A grant to r at cycle t is visible to eligibility from t+1 (`cnt` is registered). A response at t frees the slot at t+1.
- Reset mid-operation: all tags and counters are cleared. The sorter shares `rst_i`. A stray `sort_valid_i` after reset sets `err_o`.

## Test plan
- Single requester, `NREQ`=4, `LAT`=6:
  - Stimulus: r1 presents 8'h{07,03,05,01,08,02,06,04} at t=2.
  - Required: `req_ready_o`=4'b0010 at t=2; `sort_valid_o`=1 at t=2; `rsp_valid_o`=4'b0010 at t=8; `cnt[1]`=1 for t=3..8, then 0; `idle_o`=0 for t=3..8.
- All four requesters valid continuously for 8 cycles:
  - Required: grants 0,1,2,3,0,1,2,3; responses in the same order 6 cycles later; no `err_o`.
- `MAX_OUT`=2, r0 always valid, sorter delivering on time:
  - Required: r0 granted at t, t+1; blocked t+2..t+6; granted again at t+7 (slot freed by the response at t+6).
- `flush_i` asserted at t=10 with 3 vectors in flight:
  - Required: no grants from t=10; 3 responses still arrive; `idle_o` rises the cycle after the last response.
- `sort_valid_i` forced high while `tag_v`=0:
  - Required: `err_o`=1 on the next cycle; no `rsp_valid_o`; `err_o` held until `rst_i`.
- `rst_i` pulsed with 4 vectors in flight:
  - Required: `idle_o`=1 and `ptr`=0 the cycle after reset; the next grant goes to the lowest-index valid requester.
